// File: rtl/ahb_bridge_pkg.sv
// Shared codes and helpers for the AHB-to-APB bridge front end.
// Holds AHB encodings, the error FSM states and the burst-length lookup.
package ahb_bridge_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HB_SINGLE = 3'd0,
      HB_INCR   = 3'd1,
      HB_WRAP4  = 3'd2,
      HB_INCR4  = 3'd3,
      HB_WRAP8  = 3'd4,
      HB_INCR8  = 3'd5,
      HB_WRAP16 = 3'd6,
      HB_INCR16 = 3'd7
   } hburst_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } err_state_e;

   // Beat count of a burst type; 0 stands for unbounded (INCR).
   function automatic logic [4:0] burst_len(hburst_e b);
      logic [4:0] len;
      unique case (b)
         HB_SINGLE:           len = 5'd1;
         HB_INCR:             len = 5'd0;
         HB_WRAP4,  HB_INCR4:  len = 5'd4;
         HB_WRAP8,  HB_INCR8:  len = 5'd8;
         HB_WRAP16, HB_INCR16: len = 5'd16;
         default:             len = 5'd1;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Address window check and one-hot slot decode.
// Purely combinational; 64-bit math avoids wrap at the window top.
module ahb_addr_decode #(
   parameter int          NUM_SEL   = 3,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] SLOT_SIZE = 32'h0400_0000
) (
   input  logic [31:0]        haddr,
   output logic [NUM_SEL-1:0] sel,
   output logic               in_range
);

   logic [63:0] addr_w;
   logic [63:0] lo;
   logic [63:0] hi;

   // Compare the address against each slot's [lo, hi) span.
   always_comb begin
      sel    = '0;
      addr_w = {32'd0, haddr};
      lo     = '0;
      hi     = '0;
      for (int k = 0; k < NUM_SEL; k++) begin
         lo = {32'd0, BASE_ADDR} + 64'(k) * {32'd0, SLOT_SIZE};
         hi = lo + {32'd0, SLOT_SIZE};
         if (addr_w >= lo && addr_w < hi) begin
            sel[k] = 1'b1;
         end
      end
   end

   assign in_range = |sel;

endmodule

// File: rtl/ahb_slave_pipe.sv
// AHB slave front end of the APB bridge: pipelines address/data,
// validates transfers, tracks bursts and sequences ERROR responses.
module ahb_slave_pipe
   import ahb_bridge_pkg::*;
#(
   parameter int          NUM_SEL   = 3,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] SLOT_SIZE = 32'h0400_0000
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               hwrite,
   input  logic [2:0]         hsize,
   input  logic [2:0]         hburst,
   input  logic [1:0]         htrans,
   input  logic               hreadyin,
   input  logic [31:0]        haddr,
   input  logic [31:0]        hwdata,
   output logic               valid,
   output logic [NUM_SEL-1:0] tempselx,
   output logic [31:0]        haddr_1,
   output logic [31:0]        haddr_2,
   output logic [31:0]        hwdata_1,
   output logic [31:0]        hwdata_2,
   output logic               hwrite_reg,
   output logic               hwrite_reg_1,
   output logic [1:0]         hresp,
   output logic               err_stall,
   output logic               burst_last
);

   logic [31:0] haddr_1_q, haddr_1_d;
   logic [31:0] haddr_2_q, haddr_2_d;
   logic [31:0] hwdata_1_q, hwdata_1_d;
   logic [31:0] hwdata_2_q, hwdata_2_d;
   logic        hwrite_1_q, hwrite_1_d;
   logic        hwrite_2_q, hwrite_2_d;

   err_state_e  state_q, state_d;
   logic        open_q, open_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  len_q, len_d;
   logic        last_q, last_d;

   htrans_e     trans;
   logic        in_range;
   logic        idle;
   logic        is_ns;
   logic        is_seq;
   logic        active;
   logic        size_bad;
   logic        align_bad;
   logic        seq_bad;
   logic        bad;
   logic        valid_c;
   logic [4:0]  cnt_nxt;
   hresp_e      hresp_c;
   logic        stall_c;

   ahb_addr_decode #(
      .NUM_SEL   (NUM_SEL),
      .BASE_ADDR (BASE_ADDR),
      .SLOT_SIZE (SLOT_SIZE)
   ) u_dec (
      .haddr    (haddr),
      .sel      (tempselx),
      .in_range (in_range)
   );

   // Shift the address/data pipeline only when the bus is ready.
   always_comb begin
      haddr_1_d  = haddr_1_q;
      haddr_2_d  = haddr_2_q;
      hwdata_1_d = hwdata_1_q;
      hwdata_2_d = hwdata_2_q;
      hwrite_1_d = hwrite_1_q;
      hwrite_2_d = hwrite_2_q;
      if (hreadyin) begin
         haddr_1_d  = haddr;
         haddr_2_d  = haddr_1_q;
         hwdata_1_d = hwdata;
         hwdata_2_d = hwdata_1_q;
         hwrite_1_d = hwrite;
         hwrite_2_d = hwrite_1_q;
      end
   end

   // Classify the current transfer; anything seen during ERR1/ERR2 is ignored.
   always_comb begin
      trans     = htrans_e'(htrans);
      idle      = (state_q == ST_IDLE);
      is_ns     = (trans == HT_NONSEQ);
      is_seq    = (trans == HT_SEQ);
      active    = hreadyin && (is_ns || is_seq);
      size_bad  = (hsize > 3'd2);
      align_bad = ((hsize == 3'd1) && haddr[0]) ||
                  ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
      seq_bad   = is_seq &&
                  (!open_q || ((len_q != 5'd0) && (cnt_q >= len_q)));
      bad       = active && idle &&
                  (!in_range || size_bad || align_bad || seq_bad);
      valid_c   = active && idle && !bad;
   end

   // Burst tracking: open on NONSEQ, count SEQ beats, close on end/error/IDLE.
   always_comb begin
      open_d  = open_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      last_d  = 1'b0;
      cnt_nxt = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
      if (idle) begin
         if (bad) begin
            open_d = 1'b0;
         end else if (valid_c && is_ns) begin
            len_d  = burst_len(hburst_e'(hburst));
            cnt_d  = 5'd1;
            open_d = (len_d != 5'd1);
         end else if (valid_c && is_seq) begin
            cnt_d = cnt_nxt;
            if ((len_q != 5'd0) && (cnt_nxt == len_q)) begin
               open_d = 1'b0;
               last_d = 1'b1;
            end
         end else if (hreadyin && (trans == HT_IDLE)) begin
            open_d = 1'b0;
         end
      end
   end

   // Error FSM: two ERROR cycles, the first one stalling the bus.
   always_comb begin
      state_d = state_q;
      hresp_c = HRESP_OKAY;
      stall_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bad) state_d = ST_ERR1;
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
            hresp_c = HRESP_ERROR;
            stall_c = 1'b1;
         end
         ST_ERR2: begin
            state_d = ST_IDLE;
            hresp_c = HRESP_ERROR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (resetn) begin
         haddr_1_q  <= '0;
         haddr_2_q  <= '0;
         hwdata_1_q <= '0;
         hwdata_2_q <= '0;
         hwrite_1_q <= 1'b0;
         hwrite_2_q <= 1'b0;
         state_q    <= ST_IDLE;
         open_q     <= 1'b0;
         cnt_q      <= '0;
         len_q      <= '0;
         last_q     <= 1'b0;
      end else begin
         haddr_1_q  <= haddr_1_d;
         haddr_2_q  <= haddr_2_d;
         hwdata_1_q <= hwdata_1_d;
         hwdata_2_q <= hwdata_2_d;
         hwrite_1_q <= hwrite_1_d;
         hwrite_2_q <= hwrite_2_d;
         state_q    <= state_d;
         open_q     <= open_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         last_q     <= last_d;
      end
   end

   assign valid        = valid_c;
   assign haddr_1      = haddr_1_q;
   assign haddr_2      = haddr_2_q;
   assign hwdata_1     = hwdata_1_q;
   assign hwdata_2     = hwdata_2_q;
   assign hwrite_reg   = hwrite_1_q;
   assign hwrite_reg_1 = hwrite_2_q;
   assign hresp        = hresp_c;
   assign err_stall    = stall_c;
   assign burst_last   = last_q;

endmodule

// File: tb/tb_ahb_slave_pipe.sv
// Scoreboard bench for ahb_slave_pipe.
// Expectations are queued when stimulus is driven and drained at sample points.
module tb_ahb_slave_pipe;

   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam logic [63:0] SLOT = 64'h0400_0000;
   localparam int          NSEL = 3;

   localparam int S_VALID = 0;
   localparam int S_SEL   = 1;
   localparam int S_HA1   = 2;
   localparam int S_HA2   = 3;
   localparam int S_WD1   = 4;
   localparam int S_WD2   = 5;
   localparam int S_WR1   = 6;
   localparam int S_WR2   = 7;
   localparam int S_RESP  = 8;
   localparam int S_STALL = 9;
   localparam int S_LAST  = 10;

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_BUSY = 2'd1;
   localparam logic [1:0] T_NS   = 2'd2;
   localparam logic [1:0] T_SEQ  = 2'd3;

   localparam logic [2:0] B_SINGLE = 3'd0;
   localparam logic [2:0] B_INCR   = 3'd1;
   localparam logic [2:0] B_INCR4  = 3'd3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [1:0]  htrans;
   logic        hreadyin;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        valid;
   logic [2:0]  tempselx;
   logic [31:0] haddr_1;
   logic [31:0] haddr_2;
   logic [31:0] hwdata_1;
   logic [31:0] hwdata_2;
   logic        hwrite_reg;
   logic        hwrite_reg_1;
   logic [1:0]  hresp;
   logic        err_stall;
   logic        burst_last;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      int          sig;
      logic [63:0] val;
   } exp_t;

   exp_t pre_q[$];
   exp_t post_q[$];

   logic [31:0] m_ha1, m_ha2, m_wd1, m_wd2;
   logic        m_wr1, m_wr2;

   always #5 clk = ~clk;

   ahb_slave_pipe dut (
      .clk          (clk),
      .resetn       (resetn),
      .hwrite       (hwrite),
      .hsize        (hsize),
      .hburst       (hburst),
      .htrans       (htrans),
      .hreadyin     (hreadyin),
      .haddr        (haddr),
      .hwdata       (hwdata),
      .valid        (valid),
      .tempselx     (tempselx),
      .haddr_1      (haddr_1),
      .haddr_2      (haddr_2),
      .hwdata_1     (hwdata_1),
      .hwdata_2     (hwdata_2),
      .hwrite_reg   (hwrite_reg),
      .hwrite_reg_1 (hwrite_reg_1),
      .hresp        (hresp),
      .err_stall    (err_stall),
      .burst_last   (burst_last)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] dut_val(input int sig);
      logic [63:0] v;
      case (sig)
         S_VALID: v = 64'(valid);
         S_SEL:   v = 64'(tempselx);
         S_HA1:   v = 64'(haddr_1);
         S_HA2:   v = 64'(haddr_2);
         S_WD1:   v = 64'(hwdata_1);
         S_WD2:   v = 64'(hwdata_2);
         S_WR1:   v = 64'(hwrite_reg);
         S_WR2:   v = 64'(hwrite_reg_1);
         S_RESP:  v = 64'(hresp);
         S_STALL: v = 64'(err_stall);
         S_LAST:  v = 64'(burst_last);
         default: v = '1;
      endcase
      return v;
   endfunction

   function automatic logic [63:0] exp_sel(input logic [31:0] a);
      logic [63:0] aw;
      logic [63:0] idx;
      aw = {32'd0, a};
      if (aw >= BASE && aw < BASE + NSEL * SLOT) begin
         idx = (aw - BASE) / SLOT;
         return 64'd1 << idx;
      end
      return 64'd0;
   endfunction

   task automatic push_pre(input string tag, input int sig,
                           input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = v;
      pre_q.push_back(e);
   endtask

   task automatic push_post(input string tag, input int sig,
                            input logic [63:0] v);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = v;
      post_q.push_back(e);
   endtask

   task automatic drain_pre();
      exp_t e;
      while (pre_q.size() > 0) begin
         e = pre_q.pop_front();
         chk(e.tag, dut_val(e.sig), e.val);
      end
   endtask

   task automatic drain_post();
      exp_t e;
      while (post_q.size() > 0) begin
         e = post_q.pop_front();
         chk(e.tag, dut_val(e.sig), e.val);
      end
   endtask

   task automatic drv(input logic [1:0] tr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [2:0] bu,
                      input logic rdy);
      htrans   = tr;
      haddr    = a;
      hsize    = sz;
      hburst   = bu;
      hreadyin = rdy;
      hwrite   = 1'($urandom_range(0, 1));
      hwdata   = $urandom;
   endtask

   task automatic xfer(input string tag, input logic [1:0] tr,
                       input logic [31:0] a, input logic [2:0] sz,
                       input logic [2:0] bu, input logic ev);
      drv(tr, a, sz, bu, 1'b1);
      push_pre({tag, ".valid"}, S_VALID, 64'(ev));
      push_pre({tag, ".sel"}, S_SEL, exp_sel(a));
   endtask

   task automatic tick(input string tag, input logic [1:0] er,
                       input logic es, input logic el);
      if (resetn) begin
         m_ha1 = '0; m_ha2 = '0;
         m_wd1 = '0; m_wd2 = '0;
         m_wr1 = 1'b0; m_wr2 = 1'b0;
      end else if (hreadyin) begin
         m_ha2 = m_ha1; m_ha1 = haddr;
         m_wd2 = m_wd1; m_wd1 = hwdata;
         m_wr2 = m_wr1; m_wr1 = hwrite;
      end
      push_post({tag, ".ha1"}, S_HA1, 64'(m_ha1));
      push_post({tag, ".ha2"}, S_HA2, 64'(m_ha2));
      push_post({tag, ".wd1"}, S_WD1, 64'(m_wd1));
      push_post({tag, ".wd2"}, S_WD2, 64'(m_wd2));
      push_post({tag, ".wr1"}, S_WR1, 64'(m_wr1));
      push_post({tag, ".wr2"}, S_WR2, 64'(m_wr2));
      push_post({tag, ".resp"}, S_RESP, 64'(er));
      push_post({tag, ".stall"}, S_STALL, 64'(es));
      push_post({tag, ".last"}, S_LAST, 64'(el));
      #3;
      drain_pre();
      @(posedge clk);
      #1;
      drain_post();
   endtask

   task automatic idle_tick(input string tag, input logic [1:0] er,
                            input logic es);
      xfer(tag, T_IDLE, 32'h0, 3'd2, B_SINGLE, 1'b0);
      tick(tag, er, es, 1'b0);
   endtask

   task automatic err_tail(input string tag);
      idle_tick({tag, ".e2"}, 2'b01, 1'b0);
      idle_tick({tag, ".ok"}, 2'b00, 1'b0);
   endtask

   logic [31:0] hold_a1, hold_a2;

   initial begin
      resetn = 1'b1;
      drv(T_IDLE, 32'h0, 3'd2, B_SINGLE, 1'b1);
      tick("rst0", 2'b00, 1'b0, 1'b0);
      tick("rst1", 2'b00, 1'b0, 1'b0);
      resetn = 1'b0;

      xfer("single", T_NS, 32'h8400_0010, 3'd2, B_SINGLE, 1'b1);
      push_pre("single.sel010", S_SEL, 64'h2);
      tick("single", 2'b00, 1'b0, 1'b0);
      chk("single.ha1", 64'(haddr_1), 64'h8400_0010);
      idle_tick("single.i", 2'b00, 1'b0);

      xfer("oor", T_NS, 32'h9000_0000, 3'd2, B_SINGLE, 1'b0);
      tick("oor.e1", 2'b01, 1'b1, 1'b0);
      xfer("oor.ign", T_NS, 32'h8000_0000, 3'd2, B_SINGLE, 1'b0);
      tick("oor.e2", 2'b01, 1'b0, 1'b0);
      idle_tick("oor.ok", 2'b00, 1'b0);

      xfer("mis", T_NS, 32'h8000_0002, 3'd2, B_SINGLE, 1'b0);
      push_pre("mis.sel001", S_SEL, 64'h1);
      tick("mis.e1", 2'b01, 1'b1, 1'b0);
      err_tail("mis");

      xfer("sz3", T_NS, 32'h8000_0000, 3'd3, B_SINGLE, 1'b0);
      tick("sz3.e1", 2'b01, 1'b1, 1'b0);
      err_tail("sz3");

      xfer("half", T_NS, 32'h8000_0002, 3'd1, B_SINGLE, 1'b1);
      tick("half", 2'b00, 1'b0, 1'b0);

      xfer("top", T_NS, 32'h8BFF_FFFC, 3'd2, B_SINGLE, 1'b1);
      tick("top", 2'b00, 1'b0, 1'b0);
      xfer("above", T_NS, 32'h8C00_0000, 3'd2, B_SINGLE, 1'b0);
      tick("above.e1", 2'b01, 1'b1, 1'b0);
      err_tail("above");
      xfer("below", T_NS, 32'h7FFF_FFFC, 3'd2, B_SINGLE, 1'b0);
      tick("below.e1", 2'b01, 1'b1, 1'b0);
      err_tail("below");

      xfer("i4.b0", T_NS, 32'h8800_0000, 3'd2, B_INCR4, 1'b1);
      tick("i4.b0", 2'b00, 1'b0, 1'b0);
      xfer("i4.b1", T_SEQ, 32'h8800_0004, 3'd2, B_INCR4, 1'b1);
      tick("i4.b1", 2'b00, 1'b0, 1'b0);
      xfer("i4.b2", T_SEQ, 32'h8800_0008, 3'd2, B_INCR4, 1'b1);
      tick("i4.b2", 2'b00, 1'b0, 1'b0);
      xfer("i4.b3", T_SEQ, 32'h8800_000C, 3'd2, B_INCR4, 1'b1);
      tick("i4.b3", 2'b00, 1'b0, 1'b1);
      xfer("ovr", T_SEQ, 32'h8800_0010, 3'd2, B_INCR4, 1'b0);
      tick("ovr.e1", 2'b01, 1'b1, 1'b0);
      err_tail("ovr");

      hold_a1 = haddr_1;
      hold_a2 = haddr_2;
      drv(T_NS, 32'h8000_0100, 3'd2, B_SINGLE, 1'b0);
      push_pre("hold0.valid", S_VALID, 64'd0);
      tick("hold0", 2'b00, 1'b0, 1'b0);
      drv(T_NS, 32'h8000_0200, 3'd2, B_SINGLE, 1'b0);
      tick("hold1", 2'b00, 1'b0, 1'b0);
      chk("hold.ha1", 64'(haddr_1), 64'(hold_a1));
      chk("hold.ha2", 64'(haddr_2), 64'(hold_a2));

      xfer("incr.b0", T_NS, 32'h8000_1000, 3'd2, B_INCR, 1'b1);
      tick("incr.b0", 2'b00, 1'b0, 1'b0);
      for (int i = 1; i < 6; i++) begin
         xfer("incr.bn", T_SEQ, 32'h8000_1000 + 32'(4 * i), 3'd2,
              B_INCR, 1'b1);
         tick("incr.bn", 2'b00, 1'b0, 1'b0);
      end
      idle_tick("incr.i", 2'b00, 1'b0);

      xfer("busy.b0", T_NS, 32'h8000_2000, 3'd2, B_INCR4, 1'b1);
      tick("busy.b0", 2'b00, 1'b0, 1'b0);
      xfer("busy.bz", T_BUSY, 32'h8000_2004, 3'd2, B_INCR4, 1'b0);
      tick("busy.bz", 2'b00, 1'b0, 1'b0);
      xfer("busy.b1", T_SEQ, 32'h8000_2004, 3'd2, B_INCR4, 1'b1);
      tick("busy.b1", 2'b00, 1'b0, 1'b0);
      xfer("busy.b2", T_SEQ, 32'h8000_2008, 3'd2, B_INCR4, 1'b1);
      tick("busy.b2", 2'b00, 1'b0, 1'b0);
      xfer("busy.b3", T_SEQ, 32'h8000_200C, 3'd2, B_INCR4, 1'b1);
      tick("busy.b3", 2'b00, 1'b0, 1'b1);
      idle_tick("busy.i", 2'b00, 1'b0);

      xfer("mid.a0", T_NS, 32'h8400_0000, 3'd2, B_INCR4, 1'b1);
      tick("mid.a0", 2'b00, 1'b0, 1'b0);
      xfer("mid.a1", T_SEQ, 32'h8400_0004, 3'd2, B_INCR4, 1'b1);
      tick("mid.a1", 2'b00, 1'b0, 1'b0);
      xfer("mid.n0", T_NS, 32'h8400_0100, 3'd2, B_INCR4, 1'b1);
      tick("mid.n0", 2'b00, 1'b0, 1'b0);
      xfer("mid.n1", T_SEQ, 32'h8400_0104, 3'd2, B_INCR4, 1'b1);
      tick("mid.n1", 2'b00, 1'b0, 1'b0);
      xfer("mid.n2", T_SEQ, 32'h8400_0108, 3'd2, B_INCR4, 1'b1);
      tick("mid.n2", 2'b00, 1'b0, 1'b0);
      xfer("mid.n3", T_SEQ, 32'h8400_010C, 3'd2, B_INCR4, 1'b1);
      tick("mid.n3", 2'b00, 1'b0, 1'b1);
      idle_tick("mid.i", 2'b00, 1'b0);

      xfer("rb.b0", T_NS, 32'h8800_0000, 3'd2, B_INCR4, 1'b1);
      tick("rb.b0", 2'b00, 1'b0, 1'b0);
      xfer("rb.b1", T_SEQ, 32'h8800_0004, 3'd2, B_INCR4, 1'b1);
      tick("rb.b1", 2'b00, 1'b0, 1'b0);
      xfer("rb.b2", T_SEQ, 32'h8800_0008, 3'd2, B_INCR4, 1'b1);
      resetn = 1'b1;
      tick("rb.rst", 2'b00, 1'b0, 1'b0);
      resetn = 1'b0;
      xfer("rb.seq", T_SEQ, 32'h8800_000C, 3'd2, B_INCR4, 1'b0);
      tick("rb.e1", 2'b01, 1'b1, 1'b0);
      drv(T_IDLE, 32'h0, 3'd2, B_SINGLE, 1'b1);
      resetn = 1'b1;
      tick("re.rst", 2'b00, 1'b0, 1'b0);
      resetn = 1'b0;
      idle_tick("re.ok", 2'b00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
